// File: rtl/wavelet_output_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : wavelet_output_sequencer
//  Purpose  : Output stage for the wavelet filter bank. Selects one truncated
//             filter output per sample (fixed channel, round-robin scan with a
//             programmable dwell, or windowed signed peak-hold) and presents it
//             with a channel tag and a one-cycle valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module wavelet_output_sequencer #(
  parameter int NUM_FILTERS    = 8,
  parameter int SUM_TRUNCATION = 8,
  parameter int SEL_WIDTH      = 3,
  parameter int DWELL_WIDTH    = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0]   i_truncated_wavelet_out,
  input  logic                                    i_sample_valid,
  input  logic [1:0]                              i_mode,
  input  logic [SEL_WIDTH-1:0]                    i_select_output_channel,
  input  logic [DWELL_WIDTH-1:0]                  i_dwell,
  output logic [SUM_TRUNCATION-1:0]               o_multiplexed_wavelet_out,
  output logic [SEL_WIDTH-1:0]                    o_channel,
  output logic                                    o_valid
);

  localparam logic [1:0]                 C_MODE_SCAN = 2'b01;
  localparam logic [1:0]                 C_MODE_PEAK = 2'b10;
  localparam logic signed [SUM_TRUNCATION-1:0] C_PK_MIN =
    {1'b1, {(SUM_TRUNCATION-1){1'b0}}};
  localparam logic [SEL_WIDTH-1:0]       C_LAST_CH = SEL_WIDTH'(NUM_FILTERS - 1);

  // Unpacked view of the input bus, one signed word per channel
  logic signed [SUM_TRUNCATION-1:0] slices [NUM_FILTERS];

  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_unpack
    assign slices[k] = i_truncated_wavelet_out[k*SUM_TRUNCATION +: SUM_TRUNCATION];
  end

  // State and registered outputs
  logic [SEL_WIDTH-1:0]              ch_q, ch_d;
  logic [DWELL_WIDTH-1:0]            cnt_q, cnt_d;
  logic signed [SUM_TRUNCATION-1:0]  pk_q, pk_d;
  logic [1:0]                        prev_mode_q, prev_mode_d;
  logic [SEL_WIDTH-1:0]              prev_sel_q, prev_sel_d;
  logic [SUM_TRUNCATION-1:0]         out_q, out_d;
  logic [SEL_WIDTH-1:0]              chan_q, chan_d;
  logic                              valid_q, valid_d;

  // Decoded configuration and per-sample working values
  logic                              is_scan, is_peak;
  logic [SEL_WIDTH-1:0]              eff_sel;
  logic [DWELL_WIDTH-1:0]            eff_dwell;
  logic                              cfg_change;
  logic [SEL_WIDTH-1:0]              base_ch;
  logic [DWELL_WIDTH-1:0]            base_cnt;
  logic [DWELL_WIDTH:0]              cnt_inc;
  logic                              dwell_done;
  logic                              first_in_window;
  logic signed [SUM_TRUNCATION-1:0]  sel_slice, scan_slice, pk_new;

  // Sanitise live configuration and detect a change against the stored copy
  always_comb begin
    is_scan   = (i_mode == C_MODE_SCAN);
    is_peak   = (i_mode == C_MODE_PEAK);
    eff_sel   = '0;
    if (int'(i_select_output_channel) < NUM_FILTERS) eff_sel = i_select_output_channel;
    eff_dwell = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
    // Scan ignores the select input, so only mode changes restart it
    cfg_change = (i_mode != prev_mode_q) || (!is_scan && (eff_sel != prev_sel_q));
    base_ch    = cfg_change ? '0 : ch_q;
    base_cnt   = cfg_change ? '0 : cnt_q;
    cnt_inc    = {1'b0, base_cnt} + 1'b1;
    // >= so that shrinking the dwell mid-sequence ends it on the next sample
    dwell_done = (cnt_inc >= {1'b0, eff_dwell});
    first_in_window = (base_cnt == '0);
  end

  // Channel multiplexers for the selected channel and the scan pointer
  always_comb begin
    sel_slice  = slices[0];
    scan_slice = slices[0];
    for (int k = 0; k < NUM_FILTERS; k++) begin
      if (eff_sel == SEL_WIDTH'(k)) sel_slice  = slices[k];
      if (base_ch == SEL_WIDTH'(k)) scan_slice = slices[k];
    end
    pk_new = (first_in_window || (sel_slice > pk_q)) ? sel_slice : pk_q;
  end

  // Next-state logic for the sequencing state and the output word
  always_comb begin
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    pk_d        = pk_q;
    out_d       = out_q;
    chan_d      = chan_q;
    valid_d     = 1'b0;
    prev_mode_d = i_mode;
    prev_sel_d  = eff_sel;
    if (i_sample_valid) begin
      if (is_scan) begin
        out_d   = scan_slice;
        chan_d  = base_ch;
        valid_d = 1'b1;
        pk_d    = C_PK_MIN;
        if (dwell_done) begin
          cnt_d = '0;
          ch_d  = (base_ch == C_LAST_CH) ? '0 : base_ch + 1'b1;
        end else begin
          cnt_d = cnt_inc[DWELL_WIDTH-1:0];
          ch_d  = base_ch;
        end
      end else if (is_peak) begin
        ch_d = '0;
        if (dwell_done) begin
          out_d   = pk_new;
          chan_d  = eff_sel;
          valid_d = 1'b1;
          cnt_d   = '0;
          pk_d    = C_PK_MIN;
        end else begin
          cnt_d = cnt_inc[DWELL_WIDTH-1:0];
          pk_d  = pk_new;
        end
      end else begin
        out_d   = sel_slice;
        chan_d  = eff_sel;
        valid_d = 1'b1;
        ch_d    = '0;
        cnt_d   = '0;
        pk_d    = C_PK_MIN;
      end
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_q        <= '0;
      cnt_q       <= '0;
      pk_q        <= C_PK_MIN;
      prev_mode_q <= 2'b00;
      prev_sel_q  <= '0;
      out_q       <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      pk_q        <= pk_d;
      prev_mode_q <= prev_mode_d;
      prev_sel_q  <= prev_sel_d;
      out_q       <= out_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
    end
  end

  assign o_multiplexed_wavelet_out = out_q;
  assign o_channel                 = chan_q;
  assign o_valid                   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_wavelet_output_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wavelet_output_sequencer
//  Purpose  : Directed self-checking bench for wavelet_output_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wavelet_output_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] bus = '0;
  logic        vin = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [2:0]  sel = 3'd0;
  logic [7:0]  dwell = 8'd1;
  logic [7:0]  out8, out6;
  logic [2:0]  ch8, ch6;
  logic        v8, v6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wavelet_output_sequencer #(.NUM_FILTERS(8), .SUM_TRUNCATION(8), .SEL_WIDTH(3), .DWELL_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i_truncated_wavelet_out(bus), .i_sample_valid(vin),
    .i_mode(mode), .i_select_output_channel(sel), .i_dwell(dwell),
    .o_multiplexed_wavelet_out(out8), .o_channel(ch8), .o_valid(v8));

  wavelet_output_sequencer #(.NUM_FILTERS(6), .SUM_TRUNCATION(8), .SEL_WIDTH(3), .DWELL_WIDTH(8)) dut6 (
    .clk(clk), .rst(rst), .i_truncated_wavelet_out(bus[47:0]), .i_sample_valid(vin),
    .i_mode(mode), .i_select_output_channel(sel), .i_dwell(dwell),
    .o_multiplexed_wavelet_out(out6), .o_channel(ch6), .o_valid(v6));

  // Advance one clock; inputs set before the call are sampled at this edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int k, input logic [7:0] v);
    bus[k*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin = (i % 2 == 0);
      step();
      total++;
      if ({out8, ch8, v8} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got out=%h ch=%0d v=%b, expected 0/0/0", i, out8, ch8, v8);
      end
    end
    rst  = 1'b1;
    mode = 2'b00;
    sel  = 3'd5;
    set_slice(5, 8'h3C);
    vin  = 1'b1;
    step();
    vin  = 1'b0;
    total++;
    if (v8 !== 1'b1 || out8 !== 8'h3C || ch8 !== 3'd5) begin
      bad++;
      $display("FAIL fixed_after_reset: got out=%h ch=%0d v=%b, expected 3c/5/1", out8, ch8, v8);
    end
    step();
    total++;
    if (v8 !== 1'b0 || out8 !== 8'h3C || ch8 !== 3'd5) begin
      bad++;
      $display("FAIL fixed_hold: got out=%h ch=%0d v=%b, expected 3c/5/0", out8, ch8, v8);
    end
  endtask

  task automatic test_out_of_range();
    mode = 2'b00;
    sel  = 3'd7;
    set_slice(0, 8'h11);
    set_slice(7, 8'h77);
    vin  = 1'b1;
    step();
    vin  = 1'b0;
    total++;
    if (v6 !== 1'b1 || out6 !== 8'h11 || ch6 !== 3'd0) begin
      bad++;
      $display("FAIL out_of_range_sel: got out=%h ch=%0d v=%b, expected 11/0/1", out6, ch6, v6);
    end
    total++;
    if (v8 !== 1'b1 || out8 !== 8'h77 || ch8 !== 3'd7) begin
      bad++;
      $display("FAIL in_range_sel7: got out=%h ch=%0d v=%b, expected 77/7/1", out8, ch8, v8);
    end
    step();
  endtask

  // Park in fixed mode without a sample so the next scan/peak sample starts fresh
  task automatic park_fixed();
    mode = 2'b00;
    vin  = 1'b0;
    step();
  endtask

  task automatic test_scan();
    logic [2:0] exp_ch;
    logic [7:0] exp_val;
    park_fixed();
    mode  = 2'b01;
    dwell = 8'd2;
    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < 8; k++) set_slice(k, 8'((i * 16) + k));
      exp_ch  = 3'((i / 2) % 8);
      exp_val = 8'((i * 16) + int'(exp_ch));
      vin = 1'b1;
      step();
      total++;
      if (v8 !== 1'b1 || ch8 !== exp_ch || out8 !== exp_val) begin
        bad++;
        $display("FAIL scan_d2 sample %0d: got out=%h ch=%0d v=%b, expected %h/%0d/1", i, out8, ch8, v8, exp_val, exp_ch);
      end
    end
    vin = 1'b0;
    step();
    total++;
    if (v8 !== 1'b0) begin
      bad++;
      $display("FAIL scan_idle_valid: got v=%b, expected 0", v8);
    end
  endtask

  task automatic test_scan_edges();
    logic [2:0] exp_seq [5];
    for (int k = 0; k < 8; k++) set_slice(k, 8'(8'h40 + k));
    park_fixed();
    mode  = 2'b01;
    dwell = 8'd0;
    for (int i = 0; i < 10; i++) begin
      vin = 1'b1;
      step();
      total++;
      if (v8 !== 1'b1 || ch8 !== 3'(i % 8) || out8 !== 8'(8'h40 + (i % 8))) begin
        bad++;
        $display("FAIL scan_d0 sample %0d: got out=%h ch=%0d v=%b, expected ch=%0d", i, out8, ch8, v8, i % 8);
      end
    end
    park_fixed();
    mode  = 2'b01;
    dwell = 8'd4;
    exp_seq = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) dwell = 8'd1;
      vin = 1'b1;
      step();
      total++;
      if (v8 !== 1'b1 || ch8 !== exp_seq[i]) begin
        bad++;
        $display("FAIL scan_dwell_shrink sample %0d: got ch=%0d v=%b, expected ch=%0d", i, ch8, v8, exp_seq[i]);
      end
    end
    vin = 1'b0;
    step();
  endtask

  task automatic test_peak();
    logic [7:0] w1 [4];
    logic [7:0] w2 [4];
    w1 = '{8'h05, 8'hF0, 8'h7F, 8'h80};
    w2 = '{8'h80, 8'hFE, 8'h90, 8'h81};
    set_slice(3, 8'h7E);
    mode  = 2'b10;
    sel   = 3'd2;
    dwell = 8'd4;
    for (int i = 0; i < 8; i++) begin
      set_slice(2, (i < 4) ? w1[i] : w2[i-4]);
      vin = 1'b1;
      step();
      total++;
      if ((i % 4) != 3) begin
        if (v8 !== 1'b0) begin
          bad++;
          $display("FAIL peak_early_valid sample %0d: got v=%b, expected 0", i, v8);
        end
      end else begin
        if (v8 !== 1'b1 || ch8 !== 3'd2 || out8 !== ((i == 3) ? 8'h7F : 8'hFE)) begin
          bad++;
          $display("FAIL peak_result sample %0d: got out=%h ch=%0d v=%b, expected %h/2/1", i, out8, ch8, v8, (i == 3) ? 8'h7F : 8'hFE);
        end
      end
    end
    vin = 1'b0;
    step();
  endtask

  task automatic test_config_change();
    logic [7:0] c3 [4];
    c3 = '{8'h30, 8'hC0, 8'h25, 8'h10};
    mode  = 2'b10;
    sel   = 3'd2;
    dwell = 8'd4;
    set_slice(3, 8'h70);
    set_slice(2, 8'h10); vin = 1'b1; step();
    set_slice(2, 8'h20); step();
    set_slice(2, 8'h7F);
    sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      set_slice(3, c3[i]);
      step();
      total++;
      if (i < 3) begin
        if (v8 !== 1'b0) begin
          bad++;
          $display("FAIL cfg_restart_early sample %0d: got v=%b, expected 0", i, v8);
        end
      end else if (v8 !== 1'b1 || out8 !== 8'h30 || ch8 !== 3'd3) begin
        bad++;
        $display("FAIL cfg_restart_result: got out=%h ch=%0d v=%b, expected 30/3/1", out8, ch8, v8);
      end
    end
    vin = 1'b0;
    step();
    // Reset in the middle of a window must not leak the partial peak
    sel = 3'd0;
    set_slice(0, 8'h7E);
    vin = 1'b1; step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++;
    if (v8 !== 1'b0 || out8 !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_window: got out=%h v=%b, expected 00/0", out8, v8);
    end
    for (int i = 0; i < 4; i++) begin
      set_slice(0, 8'(i + 1));
      step();
      total++;
      if ((i < 3 && v8 !== 1'b0) || (i == 3 && (v8 !== 1'b1 || out8 !== 8'h04 || ch8 !== 3'd0))) begin
        bad++;
        $display("FAIL peak_after_reset sample %0d: got out=%h ch=%0d v=%b, expected 04/0 on sample 3 only", i, out8, ch8, v8);
      end
    end
    vin = 1'b0;
    step();
    total++;
    if (v8 !== 1'b0 || out8 !== 8'h04) begin
      bad++;
      $display("FAIL peak_hold: got out=%h v=%b, expected 04/0", out8, v8);
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_scan();
    test_scan_edges();
    test_peak();
    test_config_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
